// File: rtl/io_out_queue_if.sv
// io_out_queue_if
// Device-side handshake between the output queue and the output peripherals.
//   dev_valid : output stage holds an entry
//   dev_sel   : target port of the presented entry
//   dev_data  : data byte of the presented entry
//   dev_ready : device accepts the presented entry at this clock edge
// Modports: master = queue (drives valid/sel/data), slave = device (drives ready).
interface io_out_queue_if #(
  parameter int PORT_W = 3
);
  logic              dev_valid;
  logic [PORT_W-1:0] dev_sel;
  logic [7:0]        dev_data;
  logic              dev_ready;

  modport master (output dev_valid, output dev_sel, output dev_data, input dev_ready);
  modport slave  (input dev_valid, input dev_sel, input dev_data, output dev_ready);
endinterface

// File: rtl/io_out_queue.sv
// io_out_queue
// Buffered output scheduler for the CPU output ports. CPU port writes on
// main_bus are captured into an ordered FIFO of {port, data} entries and
// drained one at a time to the device interface with a valid/ready handshake.
//
// Ports:
//   clk         : system clock
//   reset       : synchronous, active-high; clears all state
//   main_bus    : CPU data bus (status byte driven here only with IO_STATUS_READ_EN)
//   port_sel    : target port for the current write
//   load_n      : active-low write strobe
//   status_oe_n : active-low status read enable; suppresses writes while low
//   flush       : synchronous discard of queue and output stage
//   dev         : device handshake (io_out_queue_if.master)
//   full/empty  : FIFO occupancy flags (output stage not counted)
//   overflow    : sticky, set when a write was dropped
//
// Optional feature macro: IO_STATUS_READ_EN
//   defined   : main_bus carries {overflow, full, empty, dev_valid, occupancy[3:0]}
//               while status_oe_n is low, Z otherwise
//   undefined : main_bus is input only, no tristate logic
//
// Drain FSM states:
//   IDLE    | output stage empty, dev_valid low
//   PRESENT | output stage holds an entry, dev_valid high until handshake
module io_out_queue #(
  parameter int DEPTH  = 8,
  parameter int PORT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [7:0]        main_bus,
  input  logic [PORT_W-1:0] port_sel,
  input  logic              load_n,
  input  logic              status_oe_n,
  input  logic              flush,
  io_out_queue_if.master    dev,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = PORT_W + 8;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          push_req;
  logic          push;
  logic          pop;

  assign empty = (occ == '0);
  assign full  = (occ == (AW+1)'(DEPTH));

  // The head moves to the output stage whenever the stage is free or is being
  // handed off this edge; dev_ready is irrelevant in IDLE.
  assign pop      = !empty && ((state == IDLE) || dev.dev_ready);
  assign push_req = !load_n && status_oe_n;
  // A full FIFO still accepts a write when the head leaves at the same edge.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push && !reset && !flush)
      mem[wr_ptr] <= {port_sel, main_bus};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      overflow      <= 1'b0;
      state         <= IDLE;
      dev.dev_valid <= 1'b0;
      if (reset) begin
        dev.dev_sel  <= '0;
        dev.dev_data <= '0;
      end
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)
        occ <= occ + 1'b1;
      else if (!push && pop)
        occ <= occ - 1'b1;

      if (push_req && !push)
        overflow <= 1'b1;

      if (pop)
        {dev.dev_sel, dev.dev_data} <= mem[rd_ptr];

      case (state)
        IDLE: begin
          if (pop) begin
            state         <= PRESENT;
            dev.dev_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (dev.dev_ready && !pop) begin
            state         <= IDLE;
            dev.dev_valid <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          dev.dev_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IO_STATUS_READ_EN
  logic [3:0] occ_ext;
  logic [7:0] status_byte;

  assign occ_ext     = 4'(occ);
  assign status_byte = {overflow, full, empty, dev.dev_valid, occ_ext};
  assign main_bus    = status_oe_n ? 8'hzz : status_byte;
`else
  // main_bus is only sampled as write data; no driver in this build.
`endif

endmodule
